reg_file_access_sequencer: RTL and testbench

Clocked successor to the combinational register-file interface. It accepts byte and register-pair (word) access requests over a valid/ready handshake and sequences them onto the two register-file ports (Rd, Rr) over one or more cycles. It returns read data or write completion over a held response handshake. It sits between the control unit / pipeline and the tri-state register file; undriven outputs are defined values, never x.

---
 rtl/reg_file_access_sequencer_pkg.sv | 8 +
 rtl/reg_file_access_sequencer_port_driver.sv | 17 +
 rtl/reg_file_access_sequencer.sv | 135 +++++++++++++
 tb/tb_reg_file_access_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/reg_file_access_sequencer_pkg.sv
// reg_file_access_sequencer_pkg: op and state encodings shared by the sequencer files
package reg_file_access_sequencer_pkg;
  typedef enum logic [1:0] {OP_RD2 = 2'b00, OP_RDW = 2'b01, OP_WR = 2'b10, OP_WRW = 2'b11} op_e;
  typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_WR_LO, ST_WR_HI, ST_RESP} state_e;
  function automatic logic is_read(input op_e op);
    return !op[1];
  endfunction
endpackage

// File: rtl/reg_file_access_sequencer_port_driver.sv
// reg_file_access_sequencer_port_driver: maps read/write intent onto one register-file port
module reg_file_access_sequencer_port_driver #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  rd,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  cs,
  output logic                  we,
  output logic                  oe,
  inout  tri   [DATA_WIDTH-1:0] data
);
  assign cs = rd | wr;
  assign we = wr;
  assign oe = rd & !wr;
  assign data = wr ? wdata : 'z;
endmodule

// File: rtl/reg_file_access_sequencer.sv
// reg_file_access_sequencer: sequences byte/pair register-file accesses; REG_SEQ_DUAL_WRITE_EN writes both pair bytes in one cycle
module reg_file_access_sequencer
  import reg_file_access_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int R_ADDR_WIDTH = 5,
  localparam int WORD_WIDTH = 2 * DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_op,
  input  logic [R_ADDR_WIDTH-1:0] req_rd_addr,
  input  logic [R_ADDR_WIDTH-1:0] req_rr_addr,
  input  logic [WORD_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [WORD_WIDTH-1:0]   resp_data,
  output logic [R_ADDR_WIDTH-1:0] rd_addr,
  output logic [R_ADDR_WIDTH-1:0] rr_addr,
  inout  tri   [DATA_WIDTH-1:0]   rd_data,
  inout  tri   [DATA_WIDTH-1:0]   rr_data,
  output logic                    rd_cs,
  output logic                    rr_cs,
  output logic                    rd_we,
  output logic                    rr_we,
  output logic                    rd_oe,
  output logic                    rr_oe
);
  state_e state;
  logic rd_rd, rd_wr, rr_rd, rr_wr;
  logic [DATA_WIDTH-1:0] rd_wd, rr_wd;
  logic [R_ADDR_WIDTH-1:0] base_lo, base_hi;
  op_e op;
`ifndef REG_SEQ_DUAL_WRITE_EN
  logic hi_pend;
  logic [R_ADDR_WIDTH-1:0] hi_addr;
  logic [DATA_WIDTH-1:0] hi_byte;
`endif
  assign op = op_e'(req_op);
  assign base_lo = {req_rd_addr[R_ADDR_WIDTH-1:1], 1'b0};
  assign base_hi = {req_rd_addr[R_ADDR_WIDTH-1:1], 1'b1};
  // Port controls are registered so each state's strobes come straight from flops; they default to idle every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      req_ready <= 1'b1;
      resp_valid <= 1'b0;
      resp_data <= '0;
      rd_addr <= '0;
      rr_addr <= '0;
      rd_rd <= 1'b0;
      rd_wr <= 1'b0;
      rr_rd <= 1'b0;
      rr_wr <= 1'b0;
      rd_wd <= '0;
      rr_wd <= '0;
`ifndef REG_SEQ_DUAL_WRITE_EN
      hi_pend <= 1'b0;
      hi_addr <= '0;
      hi_byte <= '0;
`endif
    end else begin
      rd_rd <= 1'b0;
      rd_wr <= 1'b0;
      rr_rd <= 1'b0;
      rr_wr <= 1'b0;
      rd_addr <= '0;
      rr_addr <= '0;
      case (state)
        ST_IDLE: if (req_valid) begin
          req_ready <= 1'b0;
          if (is_read(op)) begin
            state <= ST_RD;
            rd_rd <= 1'b1;
            rr_rd <= 1'b1;
            rd_addr <= op == OP_RD2 ? req_rd_addr : base_lo;
            rr_addr <= op == OP_RD2 ? req_rr_addr : base_hi;
          end else begin
            state <= ST_WR_LO;
            rd_wr <= 1'b1;
            rd_wd <= req_wdata[DATA_WIDTH-1:0];
            rd_addr <= op == OP_WR ? req_rd_addr : base_lo;
`ifdef REG_SEQ_DUAL_WRITE_EN
            rr_wr <= op == OP_WRW;
            rr_addr <= op == OP_WRW ? base_hi : '0;
            rr_wd <= req_wdata[WORD_WIDTH-1:DATA_WIDTH];
`else
            hi_pend <= op == OP_WRW;
            hi_addr <= base_hi;
            hi_byte <= req_wdata[WORD_WIDTH-1:DATA_WIDTH];
`endif
          end
        end
        ST_RD: begin
          resp_data <= {rr_data, rd_data};
          resp_valid <= 1'b1;
          state <= ST_RESP;
        end
        ST_WR_LO:
`ifndef REG_SEQ_DUAL_WRITE_EN
          if (hi_pend) begin
            rd_wr <= 1'b1;
            rd_addr <= hi_addr;
            rd_wd <= hi_byte;
            state <= ST_WR_HI;
          end else
`endif
          begin
            resp_data <= '0;
            resp_valid <= 1'b1;
            state <= ST_RESP;
          end
        ST_WR_HI: begin
          resp_data <= '0;
          resp_valid <= 1'b1;
          state <= ST_RESP;
        end
        ST_RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          req_ready <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
  reg_file_access_sequencer_port_driver #(.DATA_WIDTH(DATA_WIDTH)) u_rd (
    .rd(rd_rd), .wr(rd_wr), .wdata(rd_wd), .cs(rd_cs), .we(rd_we), .oe(rd_oe), .data(rd_data)
  );
  reg_file_access_sequencer_port_driver #(.DATA_WIDTH(DATA_WIDTH)) u_rr (
    .rd(rr_rd), .wr(rr_wr), .wdata(rr_wd), .cs(rr_cs), .we(rr_we), .oe(rr_oe), .data(rr_data)
  );
endmodule

// File: tb/tb_reg_file_access_sequencer.sv
// tb_reg_file_access_sequencer: scoreboard bench with a register-file model on both ports
module tb_reg_file_access_sequencer;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int WW = 16;
`ifdef REG_SEQ_DUAL_WRITE_EN
  localparam int WRW_LAT = 2;
`else
  localparam int WRW_LAT = 3;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic resp_ready = 1'b0;
  logic [1:0] req_op = '0;
  logic [AW-1:0] req_rd_addr = '0;
  logic [AW-1:0] req_rr_addr = '0;
  logic [WW-1:0] req_wdata = '0;
  logic req_ready, resp_valid;
  logic [WW-1:0] resp_data;
  logic [AW-1:0] rd_addr, rr_addr;
  tri [DW-1:0] rd_data, rr_data;
  logic rd_cs, rr_cs, rd_we, rr_we, rd_oe, rr_oe;
  logic [DW-1:0] mem [32];
  logic [DW-1:0] ref_mem [32];
  logic load = 1'b0;
  logic [WW-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  reg_file_access_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rd_addr(req_rd_addr), .req_rr_addr(req_rr_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .rd_addr(rd_addr), .rr_addr(rr_addr), .rd_data(rd_data), .rr_data(rr_data),
    .rd_cs(rd_cs), .rr_cs(rr_cs), .rd_we(rd_we), .rr_we(rr_we), .rd_oe(rd_oe), .rr_oe(rr_oe)
  );

  always #5 clk = ~clk;

  assign rd_data = (rd_cs & rd_oe) ? mem[rd_addr] : 'z;
  assign rr_data = (rr_cs & rr_oe) ? mem[rr_addr] : 'z;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 32; i++) mem[i] <= ref_mem[i];
    end else begin
      if (rd_cs & rd_we) mem[rd_addr] <= rd_data;
      if (rr_cs & rr_we) mem[rr_addr] <= rr_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_mem(input string tag);
    int n = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== ref_mem[i]) n++;
    check(tag, 32'(n), 32'd0);
  endtask

  task automatic check_quiet(input string tag);
    check(tag, 32'({rd_cs, rr_cs, rd_we, rr_we, rd_oe, rr_oe}), 32'd0);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] r,
                        input logic [WW-1:0] w, input int stall);
    logic [AW-1:0] b0, b1;
    logic [WW-1:0] e;
    int lat, rdc, rrc, xl;
    b0 = {a[AW-1:1], 1'b0};
    b1 = {a[AW-1:1], 1'b1};
    e = '0;
    case (op)
      2'd0: e = {ref_mem[r], ref_mem[a]};
      2'd1: e = {ref_mem[b1], ref_mem[b0]};
      2'd2: ref_mem[a] = w[7:0];
      default: begin
        ref_mem[b0] = w[7:0];
        ref_mem[b1] = w[15:8];
      end
    endcase
    xl = op == 2'd3 ? WRW_LAT : 2;
    exp_q.push_back(e);
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op = op;
    req_rd_addr = a;
    req_rr_addr = r;
    req_wdata = w;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op = 2'($urandom);
    req_rd_addr = 5'($urandom);
    req_rr_addr = 5'($urandom);
    req_wdata = 16'($urandom);
    lat = 1;
    rdc = 0;
    rrc = 0;
    forever begin
      @(negedge clk);
      check("oe_while_driven", 32'((rd_we & rd_oe) | (rr_we & rr_oe)), 32'd0);
      if (resp_valid || lat > 20) break;
      rdc += int'(rd_cs & rd_oe);
      rrc += int'(rr_cs & rr_oe);
      @(posedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(xl));
    if (op == 2'd0) begin
      check("rd_read_cycles", 32'(rdc), 32'd1);
      check("rr_read_cycles", 32'(rrc), 32'd1);
    end
    if (stall > 0) begin
      req_valid = 1'b1;
      req_op = 2'd0;
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_valid", 32'(resp_valid), 32'd1);
      check("stall_data", 32'(resp_data), 32'(e));
      check("stall_req_ready", 32'(req_ready), 32'd0);
      check_quiet("stall_ports");
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    check("resp_data", 32'(resp_data), 32'(exp_q.pop_front()));
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check("resp_released", 32'(resp_valid), 32'd0);
    check_mem("mem_contents");
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'(i * 37 + 11);
    ref_mem[3] = 8'h5A;
    ref_mem[17] = 8'hC4;
    load = 1'b1;
    repeat (2) @(posedge clk);
    #1 load = 1'b0;
    @(negedge clk);
    check_quiet("reset_ports");
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_resp_data", 32'(resp_data), 32'd0);
    check("reset_addrs", 32'({rd_addr, rr_addr}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    run_op(2'd0, 5'd3, 5'd17, 16'h0000, 0);
    run_op(2'd3, 5'd27, 5'd0, 16'hBEEF, 0);
    run_op(2'd1, 5'd26, 5'd0, 16'h0000, 0);
    run_op(2'd1, 5'd27, 5'd0, 16'h0000, 0);
    run_op(2'd2, 5'd0, 5'd0, 16'h12A5, 0);
    run_op(2'd0, 5'd26, 5'd27, 16'h0000, 5);
    run_op(2'd2, 5'd5, 5'd0, 16'h0077, 0);
    run_op(2'd0, 5'd5, 5'd9, 16'h0000, 0);
    run_op(2'd3, 5'd8, 5'd0, 16'hA1B2, 3);
    // abort a pair write in WR_LO: neither byte may land
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 2'd3;
    req_rd_addr = 5'd10;
    req_wdata = 16'h1234;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("wr_lo_active", 32'(rd_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_quiet("abort_ports");
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check_mem("abort_mem");
    run_op(2'd1, 5'd10, 5'd0, 16'h0000, 0);
    for (int k = 0; k < 8; k++)
      run_op(2'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), int'($urandom_range(0, 2)));
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
